mp_addsub_seq: RTL
==================

// Module: mp_addsub_seq
// PURPOSE
//  Multi-precision add/subtract sequencer built around one W-bit csa instance (PIPE=0).
//  Accepts LIMBS*W-bit operands over a valid/ready handshake and feeds one limb per cycle, LSB limb first.
//  Chains the carry between limbs and returns the full-width sum/difference plus flags.
//  Used where operand width exceeds the adder width and area matters more than latency.
// PARAMETERS
//  W      8  limb width; width of the shared csa
//  M      4  csa block size, passed through to csa
//  LIMBS  4  limbs per operand; total width N = W*LIMBS; LIMBS >= 1
// PORTS
//  clk        in   1  clock
//  rst_n      in   1  asynchronous, active-low reset
//  in_valid   in   1  operand request valid
//  in_ready   out  1  sequencer can accept a request
//  in_a       in   N  operand A
//  in_b       in   N  operand B
//  in_sub     in   1  1: A-B, 0: A+B
//  out_valid  out  1  result valid
//  out_ready  in   1  consumer accepts result
//  out_s      out  N  sum or difference, mod 2^N
//  out_c      out  1  carry out of MSB limb; for sub, 1 = no borrow
//  out_ovf    out  1  two's-complement signed overflow
//  out_z      out  1  out_s == 0 (MPAS_FLAGS_EN only)
// BEHAVIOUR
//  - FSM states: IDLE -> RUN on in_valid&&in_ready; RUN -> DONE after the last limb; DONE -> IDLE on out_ready.
//  - in_ready = (state==IDLE). out_valid = (state==DONE). No request overlap.
//  - Accept edge E: latch in_a, in_b, and in_sub; set limb_idx=0 and carry=in_sub.
//  - RUN cycle k (0..LIMBS-1):
//    - Drive the csa with a_k and c_in = carry.
//    - Drive b_in = (sub ? ~b_k : b_k) ^ {W{carry}}. The csa re-XORs b with c_in, so this yields a_k + beff_k + carry.
//    - At edge E+k+1, write s into out_s[k*W +: W] and set carry <= csa c_out.
//  - Latency: out_valid rises at edge E+LIMBS. It holds, with out_s/out_c/out_ovf stable, until out_ready.
//  - out_c = final carry.
//  - out_ovf = (a_msb == beff_msb) && (s_msb != a_msb), taken from the MSB limb. beff = sub ? ~b : b.
//  - out_s/out_c/out_ovf are registered. They update only in RUN and are don't-care-free (hold last value) in IDLE.
//  - Reset (rst_n low, any time, including mid-RUN):
//    - Immediately: state=IDLE, limb_idx=0, carry=0, out_valid=0, out_s=0, out_c=0, out_ovf=0 (out_z=0).
//    - Partial results are discarded.
//    - in_ready=1 from the first edge after release.
//  - LIMBS=1: RUN lasts one cycle; out_valid rises at E+1.
//  - limb_idx width = max(1, $clog2(LIMBS)). RUN exits when limb_idx == LIMBS-1; no wrap beyond.
//  - The csa clk/rst pins are tied off (clk, 1'b0); the csa is used combinationally.
//  - Inputs are sampled only on the accept edge. Changes to in_a/in_b/in_sub during RUN/DONE are ignored.
// CONFIGURATION
//  MPAS_FLAGS_EN defined:
//    - Port out_z is present.
//    - A registered running zero accumulator is cleared at accept and ANDed with (s==0) per limb.
//    - out_z is valid with out_valid.
//  MPAS_FLAGS_EN undefined:
//    - Port out_z and its logic are absent.
//    - All other behaviour is identical.
// TESTING (W=8, M=4, LIMBS=4 unless stated)
//  1. add 0xFFFFFFFF + 0x00000001 -> out_s=0x00000000, out_c=1, out_ovf=0, out_z=1; out_valid exactly 4 cycles after accept.
//  2. sub 0x00000000 - 0x00000001 -> out_s=0xFFFFFFFF, out_c=0 (borrow), out_ovf=0, out_z=0.
//  3. add 0x7FFFFFFF + 0x00000001 -> out_s=0x80000000, out_c=0, out_ovf=1.
//  4. Backpressure:
//     - Stimulus: out_ready low 3 cycles after out_valid.
//     - Required: out_valid and out_s held, in_ready=0.
//     - Stimulus: out_ready=1.
//     - Required: IDLE next edge; a new request is accepted on the following edge.
//  5. Reset mid-run:
//     - Stimulus: rst_n low after 2 limbs of 0x12345678 + 0x11111111.
//     - Required: outputs 0 asynchronously; after release, the same request gives out_s=0x23456789, out_c=0.
//  6. LIMBS=1, W=8, M=3: sub 0x80 - 0x01 -> out_s=0x7F, out_c=1, out_ovf=1; out_valid 1 cycle after accept.

Source files
------------

// File: rtl/mp_addsub_seq.sv
// mp_addsub_seq: multi-precision add/sub sequencer over one shared csa; define MPAS_FLAGS_EN to add out_z
module csa #(
  parameter int W    = 8,
  parameter int M    = 4,
  parameter int PIPE = 0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         c_in,
  output logic [W-1:0] s,
  output logic         c_out
);
  localparam int NB = (W + M - 1) / M;
  logic [W-1:0] bx, sc;
  logic [NB:0] cy;
  assign bx = b ^ {W{c_in}};
  assign cy[0] = c_in;
  for (genvar i = 0; i < NB; i++) begin : g_blk
    localparam int LO = i * M;
    localparam int BW = (W - LO < M) ? W - LO : M;
    logic [BW:0] r0, r1;
    assign r0 = {1'b0, a[LO +: BW]} + {1'b0, bx[LO +: BW]};
    assign r1 = {1'b0, a[LO +: BW]} + {1'b0, bx[LO +: BW]} + {{BW{1'b0}}, 1'b1};
    assign sc[LO +: BW] = cy[i] ? r1[BW-1:0] : r0[BW-1:0];
    assign cy[i+1] = cy[i] ? r1[BW] : r0[BW];
  end
  if (PIPE != 0) begin : g_pipe
    // optional output register stage
    always_ff @(posedge clk) begin
      if (rst) {c_out, s} <= '0;
      else {c_out, s} <= {cy[NB], sc};
    end
  end else begin : g_comb
    logic unused;
    assign unused = clk ^ rst;
    assign {c_out, s} = {cy[NB], sc};
  end
endmodule

module mp_addsub_seq #(
  parameter int W     = 8,
  parameter int M     = 4,
  parameter int LIMBS = 4,
  localparam int N    = W * LIMBS
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] in_a,
  input  logic [N-1:0] in_b,
  input  logic         in_sub,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] out_s,
  output logic         out_c,
`ifdef MPAS_FLAGS_EN
  output logic         out_z,
`endif
  output logic         out_ovf
);
  localparam int IW = (LIMBS > 1) ? $clog2(LIMBS) : 1;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state, state_d;
  logic [LIMBS-1:0][W-1:0] a_r, b_r, s_r;
  logic [IW-1:0] idx;
  logic sub_r, carry, c_r, ovf_r, last, c_out;
  logic [W-1:0] a_k, beff, b_in, s;
  assign a_k   = a_r[idx];
  assign beff  = sub_r ? ~b_r[idx] : b_r[idx];
  // csa inverts b again when c_in is set, so pre-flip to get a + beff + carry
  assign b_in  = beff ^ {W{carry}};
  assign last  = idx == IW'(LIMBS - 1);
  assign out_s = s_r;
  assign out_c = c_r;
  assign out_ovf = ovf_r;
  csa #(.W(W), .M(M), .PIPE(0)) u_csa (
    .clk(clk), .rst(1'b0), .a(a_k), .b(b_in), .c_in(carry), .s(s), .c_out(c_out)
  );
  // state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else state <= state_d;
  end
  // next state and handshake outputs
  always_comb begin
    in_ready  = state == IDLE;
    out_valid = state == DONE;
    state_d   = (state == IDLE && in_valid) ? RUN :
                (state == RUN && last) ? DONE :
                (state == DONE && out_ready) ? IDLE : state;
  end
  // operand capture and per-limb accumulation of result and flags
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_r <= '0;
      b_r <= '0;
      sub_r <= 1'b0;
      idx <= '0;
      carry <= 1'b0;
      s_r <= '0;
      c_r <= 1'b0;
      ovf_r <= 1'b0;
    end else if (state == IDLE && in_valid) begin
      a_r <= in_a;
      b_r <= in_b;
      sub_r <= in_sub;
      idx <= '0;
      carry <= in_sub;
    end else if (state == RUN) begin
      s_r[idx] <= s;
      carry <= c_out;
      c_r <= c_out;
      ovf_r <= (a_k[W-1] == beff[W-1]) && (s[W-1] != a_k[W-1]);
      idx <= last ? idx : idx + 1'b1;
    end
  end
`ifdef MPAS_FLAGS_EN
  // running zero flag over all limbs of the current operation
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) out_z <= 1'b0;
    else if (state == IDLE && in_valid) out_z <= 1'b1;
    else if (state == RUN) out_z <= out_z & (s == '0);
  end
`endif
endmodule
